// File: rtl/porta_pkg.sv
// Shared types and helpers for the door controller.
// Holds the door FSM state encoding and the timer width calculation.
package porta_pkg;

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    ABRINDO  = 2'd1,
    ABERTA   = 2'd2,
    FECHANDO = 2'd3
  } estado_porta_t;

  // Width that holds the largest reload value without wrapping.
  function automatic int cnt_width(input int hold, input int open, input int close,
                                   input int max_obs);
    int mx;
    mx = hold;
    if (open > mx)    mx = open;
    if (close > mx)   mx = close;
    if (max_obs > mx) mx = max_obs;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/porta_timer.sv
// Loadable down-counter shared by every timed door state.
// Decrements only while nonzero, so it never wraps; zero is a flag for the FSM.
module porta_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controle_porta.sv
// Elevator door controller: closed/opening/open/closing FSM with dwell and
// motor timers. Optional nudge (forced close on long obstruction): PORTA_NUDGE_EN.
module controle_porta
  import porta_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int OPEN_CYCLES  = 2,
  parameter int CLOSE_CYCLES = 2,
  parameter int MAX_OBSTRUCT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic chegada,
  input  logic sensor,
  input  logic segurar,
  input  logic fechar,
  input  logic estadomover,
  output logic mover,
  output logic porta_aberta,
  output logic motor_abrir,
  output logic motor_fechar,
  output logic alarme
);

  localparam int W = cnt_width(HOLD_CYCLES, OPEN_CYCLES, CLOSE_CYCLES, MAX_OBSTRUCT);
  localparam logic [W-1:0] HOLD_V  = W'(HOLD_CYCLES - 1);
  localparam logic [W-1:0] OPEN_V  = W'(OPEN_CYCLES - 1);
  localparam logic [W-1:0] CLOSE_V = W'(CLOSE_CYCLES - 1);

  estado_porta_t state, state_n;
  logic          obst;
  logic          t_load, t_dec, t_zero;
  logic [W-1:0]  t_val;
  logic          nudge_on;

`ifdef PORTA_NUDGE_EN
  localparam logic [W-1:0] MAX_V = W'(MAX_OBSTRUCT - 1);
  logic [W-1:0] obs_cnt, obs_n;
  logic         nudge, nudge_n;
  assign nudge_on = nudge;
`else
  assign nudge_on = 1'b0;
`endif

  assign obst = ~estadomover & (sensor | segurar);

  porta_timer #(.W(W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
`ifdef PORTA_NUDGE_EN
    obs_n   = obs_cnt;
    nudge_n = nudge;
`endif
    // Motion outside FECHADA is illegal: everything freezes.
    if (!estadomover) begin
      unique case (state)
        FECHADA: begin
          if (chegada || segurar) begin
            state_n = ABRINDO;
            t_load  = 1'b1;
            t_val   = OPEN_V;
          end
        end
        ABRINDO: begin
          if (t_zero) begin
            state_n = ABERTA;
            t_load  = 1'b1;
            t_val   = HOLD_V;
          end else begin
            t_dec = 1'b1;
          end
        end
        ABERTA: begin
          if (obst) begin
`ifdef PORTA_NUDGE_EN
            if (obs_cnt == MAX_V) begin
              state_n = FECHANDO;
              t_load  = 1'b1;
              t_val   = CLOSE_V;
              nudge_n = 1'b1;
            end else begin
              obs_n  = obs_cnt + 1'b1;
              t_load = 1'b1;
              t_val  = HOLD_V;
            end
`else
            t_load = 1'b1;
            t_val  = HOLD_V;
`endif
          end else if (fechar || t_zero) begin
            state_n = FECHANDO;
            t_load  = 1'b1;
            t_val   = CLOSE_V;
          end else begin
            t_dec = 1'b1;
          end
        end
        FECHANDO: begin
          if (obst && !nudge_on) begin
            state_n = ABRINDO;
            t_load  = 1'b1;
            t_val   = OPEN_V;
          end else if (t_zero) begin
            state_n = FECHADA;
          end else begin
            t_dec = 1'b1;
          end
        end
        default: state_n = FECHADA;
      endcase
`ifdef PORTA_NUDGE_EN
      if (state_n != ABERTA || !obst) obs_n = '0;
      if (state_n == FECHADA) nudge_n = 1'b0;
`endif
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FECHADA;
      mover        <= 1'b1;
      porta_aberta <= 1'b0;
      motor_abrir  <= 1'b0;
      motor_fechar <= 1'b0;
      alarme       <= 1'b0;
    end else begin
      state        <= state_n;
      mover        <= (state_n == FECHADA);
      porta_aberta <= (state_n == ABERTA);
      motor_abrir  <= (state_n == ABRINDO);
      motor_fechar <= (state_n == FECHANDO);
`ifdef PORTA_NUDGE_EN
      alarme       <= nudge_n;
`else
      alarme       <= 1'b0;
`endif
    end
  end

`ifdef PORTA_NUDGE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      obs_cnt <= '0;
      nudge   <= 1'b0;
    end else begin
      obs_cnt <= obs_n;
      nudge   <= nudge_n;
    end
  end
`endif

  a_no_motion_open : assert property (
    @(posedge clock) disable iff (reset) !(estadomover && state != FECHADA));

endmodule

// File: tb/tb_controle_porta.sv
// Self-checking bench for controle_porta: directed door scenarios with literal
// traces plus randomized traffic checked every cycle against a behavioural model.
module tb_controle_porta;

  localparam int HOLD  = 4;
  localparam int OPEN  = 2;
  localparam int CLOSE = 2;
  localparam int MAXOB = 8;
`ifdef PORTA_NUDGE_EN
  localparam bit NUDGE = 1'b1;
`else
  localparam bit NUDGE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chegada = 1'b0, sensor = 1'b0, segurar = 1'b0, fechar = 1'b0, estadomover = 1'b0;
  logic mover, porta_aberta, motor_abrir, motor_fechar, alarme;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  controle_porta #(
    .HOLD_CYCLES(HOLD), .OPEN_CYCLES(OPEN), .CLOSE_CYCLES(CLOSE), .MAX_OBSTRUCT(MAXOB)
  ) dut (
    .clock(clock), .reset(reset), .chegada(chegada), .sensor(sensor),
    .segurar(segurar), .fechar(fechar), .estadomover(estadomover),
    .mover(mover), .porta_aberta(porta_aberta), .motor_abrir(motor_abrir),
    .motor_fechar(motor_fechar), .alarme(alarme)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase code 0 closed, 1 opening, 2 open, 3 closing -> {mover,aberta,abrir,fechar}.
  function automatic logic [3:0] vec_of(input int ph);
    case (ph)
      0: return 4'b1000;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Behavioural model: phase plus elapsed cycles in it, obstruction run length.
  int m_ph = 0, m_age = 0, m_run = 0;
  bit m_nud = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_ph = 0; m_age = 0; m_run = 0; m_nud = 1'b0;
    end else if (!estadomover) begin
      case (m_ph)
        0: if (chegada || segurar) begin m_ph = 1; m_age = 0; end
        1: if (m_age == OPEN - 1) begin m_ph = 2; m_age = 0; m_run = 0; end
           else m_age++;
        2: if (sensor || segurar) begin
             if (NUDGE && m_run + 1 == MAXOB) begin
               m_ph = 3; m_age = 0; m_run = 0; m_nud = 1'b1;
             end else begin
               m_run++; m_age = 0;
             end
           end else if (fechar || m_age == HOLD - 1) begin
             m_ph = 3; m_age = 0; m_run = 0;
           end else begin
             m_age++; m_run = 0;
           end
        default: if ((sensor || segurar) && !m_nud) begin m_ph = 1; m_age = 0; end
                 else if (m_age == CLOSE - 1) begin m_ph = 0; m_age = 0; m_nud = 1'b0; end
                 else m_age++;
      endcase
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model mover",        mover,        m_ph == 0);
      check("model porta_aberta", porta_aberta, m_ph == 2);
      check("model motor_abrir",  motor_abrir,  m_ph == 1);
      check("model motor_fechar", motor_fechar, m_ph == 3);
      check("model alarme",       alarme,       m_nud);
    end
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    chegada = 0; sensor = 0; segurar = 0; fechar = 0; estadomover = 0;
  endtask

  // Element e of exp is the phase expected after edge e; chegada is sampled at edge 0.
  task automatic run_trace(input string name, input int exp[$], input int aa, input int ab,
                           input int sa, input int sb, input int fa, input int fb,
                           input int ga, input int gb);
    for (int e = 0; e < exp.size(); e++) begin
      chegada = (e == 0);
      sensor  = (e >= sa && e <= sb);
      fechar  = (e >= fa && e <= fb);
      segurar = (e >= ga && e <= gb);
      step();
      check($sformatf("%s[%0d] outs", name, e),
            {mover, porta_aberta, motor_abrir, motor_fechar}, vec_of(exp[e]));
      check($sformatf("%s[%0d] alarme", name, e), alarme, (e >= aa && e <= ab));
    end
    idle_inputs();
    step();
  endtask

  initial begin
    int q[$];

    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clock);
    check("reset outs", {mover, porta_aberta, motor_abrir, motor_fechar}, 4'b1000);
    check("reset alarme", alarme, 1'b0);
    reset = 0;
    cmp_en = 1;
    step();

    // 1: plain cycle 2 opening, 4 open, 2 closing, closed after edge 8.
    q = '{1, 1, 2, 2, 2, 2, 3, 3, 0};
    run_trace("basic", q, 1, 0, 1, 0, 1, 0, 1, 0);

    // 2: sensor in 3rd open cycle stretches open to 7 cycles.
    q = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3, 0};
    run_trace("sens_open", q, 1, 0, 5, 5, 1, 0, 1, 0);

    // 3: sensor in 1st closing cycle reopens fully.
    q = '{1, 1, 2, 2, 2, 2, 3, 1, 1, 2, 2, 2, 2, 3, 3, 0};
    run_trace("reopen", q, 1, 0, 7, 7, 1, 0, 1, 0);

    // 4a: close button in 1st open cycle.
    q = '{1, 1, 2, 3, 3, 0};
    run_trace("fechar", q, 1, 0, 1, 0, 3, 3, 1, 0);

    // 4b: close button together with hold button keeps door open.
    q = '{1, 1, 2, 2, 2, 2, 2, 3, 3, 0};
    run_trace("fech_seg", q, 1, 0, 1, 0, 3, 3, 3, 3);

    // 5: car moving, requests ignored.
    estadomover = 1;
    for (int i = 0; i < 10; i++) begin
      chegada = 1'($urandom_range(1));
      segurar = 1'($urandom_range(1));
      sensor  = 1'($urandom_range(1));
      fechar  = 1'($urandom_range(1));
      step();
      check($sformatf("moving[%0d] outs", i),
            {mover, porta_aberta, motor_abrir, motor_fechar}, 4'b1000);
    end
    idle_inputs();
    step();

    // 6: sensor held continuously.
    q = '{1, 1};
`ifdef PORTA_NUDGE_EN
    repeat (8) q.push_back(2);
    q.push_back(3); q.push_back(3); q.push_back(0);
    run_trace("nudge", q, 10, 11, 0, 12, 1, 0, 1, 0);
`else
    repeat (24) q.push_back(2);
    q.push_back(3); q.push_back(3); q.push_back(0);
    run_trace("held", q, 1, 0, 0, 22, 1, 0, 1, 0);
`endif

    // Randomized traffic; motion only while the door is shut.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(99) == 0);
      estadomover = (m_ph == 0) && ($urandom_range(9) < 3);
      chegada     = ($urandom_range(9) == 0);
      sensor      = ($urandom_range(9) < 2);
      segurar     = ($urandom_range(19) == 0);
      fechar      = ($urandom_range(9) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
